// File: rtl/lc3_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_uart_mmio
//  Purpose  : LC-3 memory-mapped keyboard/display device registers backed by
//             a UART. Received bytes are queued in a small FIFO; transmit
//             bytes are handed to uart_tx one at a time.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_uart_mmio #(
   parameter int          RX_DEPTH  = 4,
   parameter logic [15:0] KBSR_ADDR = 16'hFE00
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Mem_En,
   input  logic        i_Mem_WE,
   input  logic [15:0] i_Addr,
   input  logic [15:0] i_Wdata,
   output logic        o_Hit,
   output logic [15:0] o_Rdata,
   input  logic        i_Rx_DV,
   input  logic [7:0]  i_Rx_Byte,
   output logic        o_Tx_DV,
   output logic [7:0]  o_Tx_Byte,
   input  logic        i_Tx_Done,
   output logic        o_Kb_Int,
   output logic        o_Disp_Int
);

   localparam int          AW        = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int          CW        = AW + 1;
   localparam logic [15:0] KBDR_ADDR = KBSR_ADDR + 16'd2;
   localparam logic [15:0] DSR_ADDR  = KBSR_ADDR + 16'd4;
   localparam logic [15:0] DDR_ADDR  = KBSR_ADDR + 16'd6;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2
   } tx_state_t;

   tx_state_t     state_q;
   logic          tx_dv_q;
   logic [7:0]    tx_byte_q;
   logic [7:0]    mem_q [RX_DEPTH];
   logic [AW-1:0] rptr_q, wptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          kb_ie_q, disp_ie_q, ovr_q;
   logic [15:0]   rdata_q, rdata_d;
   logic          kb_int_q, disp_int_q;

   logic sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;
   logic bus_rd, bus_wr;
   logic empty, full, drdy;
   logic pop, push, ovr_set;

   assign sel_kbsr = (i_Addr == KBSR_ADDR);
   assign sel_kbdr = (i_Addr == KBDR_ADDR);
   assign sel_dsr  = (i_Addr == DSR_ADDR);
   assign sel_ddr  = (i_Addr == DDR_ADDR);
   assign o_Hit    = sel_kbsr | sel_kbdr | sel_dsr | sel_ddr;

   assign bus_rd   = i_Mem_En & ~i_Mem_WE;
   assign bus_wr   = i_Mem_En &  i_Mem_WE;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(RX_DEPTH));
   assign drdy     = (state_q == IDLE);

   // A pop in the same cycle frees the slot, so a push into a full FIFO is
   // only dropped (and flagged as overrun) when nothing is being read out.
   assign pop      = bus_rd & sel_kbdr & ~empty;
   assign push     = i_Rx_DV & (~full | pop);
   assign ovr_set  = i_Rx_DV & full & ~pop;

   // Occupancy next-state from push/pop combination
   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + CW'(1);
      else if (pop && !push)
         count_d = count_q - CW'(1);
   end

   // Read-data mux; o_Rdata holds unless a read access occurs
   always_comb begin
      rdata_d = rdata_q;
      if (bus_rd) begin
         rdata_d = 16'h0000;
         if (sel_kbsr)
            rdata_d = {~empty, kb_ie_q, ovr_q, 13'b0};
         else if (sel_kbdr && !empty)
            rdata_d = {8'h00, mem_q[rptr_q]};
         else if (sel_dsr)
            rdata_d = {drdy, disp_ie_q, 14'b0};
      end
   end

   // FIFO storage; validity is tracked by the pointers, so no reset needed
   always_ff @(posedge i_Clock) begin
      if (push)
         mem_q[wptr_q] <= i_Rx_Byte;
   end

   // FIFO pointers, control bits, read data and interrupt requests
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rptr_q     <= '0;
         wptr_q     <= '0;
         count_q    <= '0;
         kb_ie_q    <= 1'b0;
         disp_ie_q  <= 1'b0;
         ovr_q      <= 1'b0;
         rdata_q    <= 16'h0000;
         kb_int_q   <= 1'b0;
         disp_int_q <= 1'b0;
      end else begin
         if (push)
            wptr_q <= wptr_q + AW'(1);
         if (pop)
            rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         rdata_q <= rdata_d;

         if (bus_wr && sel_kbsr)
            kb_ie_q <= i_Wdata[14];
         if (bus_wr && sel_dsr)
            disp_ie_q <= i_Wdata[14];

         // A hardware overrun wins over a same-cycle software clear
         if (ovr_set)
            ovr_q <= 1'b1;
         else if (bus_wr && sel_kbsr && i_Wdata[13])
            ovr_q <= 1'b0;

         kb_int_q   <= ~empty & kb_ie_q;
         disp_int_q <= drdy & disp_ie_q;
      end
   end

   // Transmit sequencer: one-cycle launch pulse, then wait for Done
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q   <= IDLE;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
      end else begin
         case (state_q)
            IDLE: begin
               tx_dv_q <= 1'b0;
               if (bus_wr && sel_ddr) begin
                  tx_byte_q <= i_Wdata[7:0];
                  tx_dv_q   <= 1'b1;
                  state_q   <= LAUNCH;
               end
            end
            LAUNCH: begin
               tx_dv_q <= 1'b0;
               state_q <= BUSY;
            end
            BUSY: begin
               tx_dv_q <= 1'b0;
               if (i_Tx_Done)
                  state_q <= IDLE;
            end
            default: begin
               tx_dv_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_Rdata    = rdata_q;
   assign o_Tx_DV    = tx_dv_q;
   assign o_Tx_Byte  = tx_byte_q;
   assign o_Kb_Int   = kb_int_q;
   assign o_Disp_Int = disp_int_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_uart_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_uart_mmio
//  Purpose  : Directed self-checking bench for lc3_uart_mmio
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc3_uart_mmio;

   localparam logic [15:0] KBSR = 16'hFE00;
   localparam logic [15:0] KBDR = 16'hFE02;
   localparam logic [15:0] DSR  = 16'hFE04;
   localparam logic [15:0] DDR  = 16'hFE06;

   logic        i_Clock = 1'b0;
   logic        i_Reset = 1'b1;
   logic        i_Mem_En = 1'b0;
   logic        i_Mem_WE = 1'b0;
   logic [15:0] i_Addr = 16'h0000;
   logic [15:0] i_Wdata = 16'h0000;
   logic        o_Hit;
   logic [15:0] o_Rdata;
   logic        i_Rx_DV = 1'b0;
   logic [7:0]  i_Rx_Byte = 8'h00;
   logic        o_Tx_DV;
   logic [7:0]  o_Tx_Byte;
   logic        i_Tx_Done = 1'b0;
   logic        o_Kb_Int;
   logic        o_Disp_Int;

   int checks = 0;
   int errors = 0;

   lc3_uart_mmio #(.RX_DEPTH(4), .KBSR_ADDR(16'hFE00)) dut (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .i_Mem_En   (i_Mem_En),
      .i_Mem_WE   (i_Mem_WE),
      .i_Addr     (i_Addr),
      .i_Wdata    (i_Wdata),
      .o_Hit      (o_Hit),
      .o_Rdata    (o_Rdata),
      .i_Rx_DV    (i_Rx_DV),
      .i_Rx_Byte  (i_Rx_Byte),
      .o_Tx_DV    (o_Tx_DV),
      .o_Tx_Byte  (o_Tx_Byte),
      .i_Tx_Done  (i_Tx_Done),
      .o_Kb_Int   (o_Kb_Int),
      .o_Disp_Int (o_Disp_Int)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle 1 time unit past the edge
   task automatic tick();
      @(posedge i_Clock);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      i_Mem_En = 1'b1; i_Mem_WE = 1'b1; i_Addr = a; i_Wdata = d;
      tick();
      i_Mem_En = 1'b0; i_Mem_WE = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      i_Mem_En = 1'b1; i_Mem_WE = 1'b0; i_Addr = a;
      tick();
      d = o_Rdata;
      i_Mem_En = 1'b0;
   endtask

   task automatic rx_push(input logic [7:0] b);
      i_Rx_DV = 1'b1; i_Rx_Byte = b;
      tick();
      i_Rx_DV = 1'b0;
   endtask

   task automatic tx_done();
      i_Tx_Done = 1'b1;
      tick();
      i_Tx_Done = 1'b0;
   endtask

   logic [15:0] rd;
   logic [15:0] exp_q [$];

   initial begin
      // ---- reset state
      repeat (3) tick();
      i_Reset = 1'b0;
      chk("rst_rdata",    o_Rdata,              16'h0000);
      chk("rst_txdv",     {15'b0, o_Tx_DV},     16'h0000);
      chk("rst_txbyte",   {8'b0, o_Tx_Byte},    16'h0000);
      bus_read(KBSR, rd); chk("rst_kbsr", rd, 16'h0000);
      bus_read(DSR,  rd); chk("rst_dsr",  rd, 16'h8000);
      chk("rst_kbint",    {15'b0, o_Kb_Int},    16'h0000);
      chk("rst_dispint",  {15'b0, o_Disp_Int},  16'h0000);

      // ---- address decode
      i_Addr = DDR;      #1; chk("hit_ddr",  {15'b0, o_Hit}, 16'h0001);
      i_Addr = 16'hFE08; #1; chk("hit_fe08", {15'b0, o_Hit}, 16'h0000);
      i_Addr = 16'hFE01; #1; chk("hit_fe01", {15'b0, o_Hit}, 16'h0000);

      // ---- single byte receive
      rx_push(8'h3F);
      bus_read(KBSR, rd); chk("rx1_kbsr",   rd, 16'h8000);
      bus_read(KBDR, rd); chk("rx1_kbdr",   rd, 16'h003F);
      tick();             chk("rdata_hold", o_Rdata, 16'h003F);
      bus_read(KBSR, rd); chk("rx1_kbsr2",  rd, 16'h0000);
      bus_read(16'hFE08, rd); chk("unmapped_rd", rd, 16'h0000);

      // ---- keyboard interrupt
      bus_write(KBSR, 16'h4000);
      bus_read(KBSR, rd); chk("kbie_kbsr", rd, 16'h4000);
      rx_push(8'h12);
      tick();             chk("kbint_on",  {15'b0, o_Kb_Int}, 16'h0001);
      bus_read(KBDR, rd); chk("kbint_kbdr", rd, 16'h0012);
      tick();             chk("kbint_off", {15'b0, o_Kb_Int}, 16'h0000);
      bus_write(KBSR, 16'h0000);

      // ---- transmit
      bus_write(DDR, 16'h12AB);
      chk("tx_dv_hi",   {15'b0, o_Tx_DV}, 16'h0001);
      chk("tx_byte",    {8'b0, o_Tx_Byte}, 16'h00AB);
      tick();
      chk("tx_dv_lo",   {15'b0, o_Tx_DV}, 16'h0000);
      bus_read(DSR, rd); chk("tx_dsr_busy", rd, 16'h0000);
      bus_write(DDR, 16'h0055);
      chk("tx_ign_dv",   {15'b0, o_Tx_DV}, 16'h0000);
      chk("tx_ign_byte", {8'b0, o_Tx_Byte}, 16'h00AB);
      bus_write(DSR, 16'h4000);
      bus_read(DSR, rd); chk("tx_dsr_ie_busy", rd, 16'h4000);
      chk("dispint_busy", {15'b0, o_Disp_Int}, 16'h0000);
      bus_read(DDR, rd); chk("ddr_rd", rd, 16'h0000);
      tx_done();
      bus_read(DSR, rd); chk("tx_dsr_done", rd, 16'hC000);
      chk("dispint_on", {15'b0, o_Disp_Int}, 16'h0001);
      bus_write(DSR, 16'h0000);
      tick();
      chk("dispint_off", {15'b0, o_Disp_Int}, 16'h0000);

      // ---- overrun
      for (int i = 1; i <= 5; i++) rx_push(8'(i));
      bus_read(KBSR, rd); chk("ovr_kbsr", rd, 16'hA000);
      for (int i = 1; i <= 4; i++) begin
         bus_read(KBDR, rd); chk("ovr_pop", rd, 16'(i));
      end
      bus_read(KBDR, rd); chk("ovr_empty", rd, 16'h0000);
      bus_write(KBSR, 16'h2000);
      bus_read(KBSR, rd); chk("ovr_clr", rd, 16'h0000);

      // ---- push and pop together while full
      for (int i = 0; i < 4; i++) rx_push(8'h10 + 8'(i));
      i_Rx_DV = 1'b1; i_Rx_Byte = 8'h99;
      bus_read(KBDR, rd);
      i_Rx_DV = 1'b0;
      chk("full_pp_rd", rd, 16'h0010);
      bus_read(KBSR, rd); chk("full_pp_kbsr", rd, 16'h8000);
      exp_q = '{16'h0011, 16'h0012, 16'h0013, 16'h0099, 16'h0000};
      foreach (exp_q[k]) begin
         bus_read(KBDR, rd); chk("full_pp_drain", rd, exp_q[k]);
      end

      // ---- push and read together while empty
      i_Rx_DV = 1'b1; i_Rx_Byte = 8'h5A;
      bus_read(KBDR, rd);
      i_Rx_DV = 1'b0;
      chk("empty_pp_rd", rd, 16'h0000);
      bus_read(KBDR, rd); chk("empty_pp_next", rd, 16'h005A);

      // ---- reset mid-transmission with bytes queued
      bus_write(DDR, 16'h0077);
      tick();
      rx_push(8'hC1);
      rx_push(8'hC2);
      i_Reset = 1'b1;
      tick();
      i_Reset = 1'b0;
      chk("mid_rst_txbyte", {8'b0, o_Tx_Byte}, 16'h0000);
      bus_read(DSR,  rd); chk("mid_rst_dsr",  rd, 16'h8000);
      bus_read(KBSR, rd); chk("mid_rst_kbsr", rd, 16'h0000);
      tx_done();
      for (int i = 0; i < 4; i++) begin
         chk("late_done_txdv", {15'b0, o_Tx_DV}, 16'h0000);
         tick();
      end
      bus_read(DSR, rd); chk("late_done_dsr", rd, 16'h8000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lc3_uart_mmio.md
Name: lc3_uart_mmio

Overview:
- Memory-mapped UART controller for the LC-3 core. Presents the standard keyboard/display device registers (KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06) to the CPU memory bus.
- Buffers bytes arriving from uart_rx in a small FIFO.
- Sequences uart_tx one byte at a time, using the DV/Done handshake.
- Generates keyboard and display interrupt requests.

Parameters:
- RX_DEPTH, 4, number of entries in the receive FIFO (power of 2, minimum 2).
- KBSR_ADDR, 16'hFE00, keyboard status register address. KBDR is at +2, DSR at +4, DDR at +6.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous, active-high reset
- i_Mem_En  in  1  bus access strobe, one cycle per access
- i_Mem_WE  in  1  1 = write, 0 = read
- i_Addr  in  16  bus address
- i_Wdata  in  16  write data
- o_Hit  out  1  combinational; high when i_Addr matches one of the four registers
- o_Rdata  out  16  registered read data
- i_Rx_DV  in  1  one-cycle pulse from uart_rx
- i_Rx_Byte  in  8  received byte
- o_Tx_DV  out  1  one-cycle launch pulse to uart_tx
- o_Tx_Byte  out  8  byte to transmit
- i_Tx_Done  in  1  one-cycle pulse from uart_tx at the end of the stop bit
- o_Kb_Int  out  1  keyboard interrupt request
- o_Disp_Int  out  1  display interrupt request

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge):
  - FIFO emptied; read/write pointers and count cleared.
  - KB_IE=0, DISP_IE=0, OVR=0, TX FSM=IDLE.
  - Outputs: o_Rdata=0, o_Tx_DV=0, o_Tx_Byte=0, o_Kb_Int=0, o_Disp_Int=0.
  - Reset during a transmission abandons it. uart_tx still completes its frame; any i_Tx_Done seen while IDLE is ignored.
- Register map (reads):
  - KBSR = {RDY, KB_IE, OVR, 13'b0}, where RDY = FIFO non-empty.
  - KBDR = {8'b0, FIFO head}.
  - DSR = {DRDY, DISP_IE, 14'b0}, where DRDY = (state==IDLE).
  - DDR reads x0000.
  - Unmapped addresses read x0000.
- Read timing: a read access (i_Mem_En=1, i_Mem_WE=0) at edge N makes o_Rdata valid after edge N. o_Rdata holds its value until the next read access.
- KBDR read when non-empty pops the head in the same cycle. KBDR read when empty returns x0000 and does not pop.
- KBSR write: KB_IE <= i_Wdata[14]; OVR cleared if i_Wdata[13]=1 (write-1-to-clear). RDY is not writable.
- DSR write: DISP_IE <= i_Wdata[14].
- DDR write:
  - If state==IDLE, latch i_Wdata[7:0] into o_Tx_Byte and go to LAUNCH.
  - Otherwise the write is ignored: no state change, o_Tx_Byte unchanged.
- Writes to KBDR and to unmapped addresses are ignored.
- RX FIFO:
  - i_Rx_DV pushes i_Rx_Byte.
  - Push when full drops the byte and sets OVR (sticky).
  - Push and pop in the same cycle when full: both occur, count unchanged, OVR not set.
  - Push and KBDR read in the same cycle when empty: the read returns x0000; the byte is stored and count becomes 1.
  - Pointers wrap modulo RX_DEPTH; count ranges 0..RX_DEPTH.
- TX FSM:
  - IDLE --DDR write--> LAUNCH.
  - LAUNCH: o_Tx_DV=1 for exactly one cycle, then BUSY.
  - BUSY --i_Tx_Done--> IDLE. DRDY is 1 in the cycle after the Done edge.
  - o_Tx_Byte is stable from LAUNCH until the FSM returns to IDLE.
- Interrupts (registered, updated every cycle):
  - o_Kb_Int = RDY & KB_IE.
  - o_Disp_Int = DRDY & DISP_IE.
- Bus writes and FIFO pushes are processed in the same cycle without conflict. Status changes are visible on the next read.

Test Plan:
- Reset, then read KBSR and DSR -> x0000 and x8000. o_Kb_Int=0, o_Disp_Int=0.
- Pulse i_Rx_DV with x3F, read KBSR, read KBDR, read KBSR -> x8000, x003F, x0000. With KB_IE=1 (write KBSR x4000): o_Kb_Int=1 between push and pop, 0 after.
- Write DDR xAB while IDLE -> o_Tx_DV high exactly 1 cycle with o_Tx_Byte=xAB; DSR reads x0000 while busy. Write DDR x55 during BUSY -> ignored. After i_Tx_Done, DSR=x8000; with DISP_IE=1, o_Disp_Int=1.
- Push 5 bytes x01..x05 with RX_DEPTH=4 -> KBSR=xA000 (RDY+OVR); KBDR pops return x01..x04, then x0000. Write KBSR x2000 -> OVR clears, KBSR=x0000.
- With FIFO full, push x99 in the same cycle as a KBDR read -> read returns the oldest byte; OVR stays 0; x99 is popped last.
- Assert i_Reset mid-BUSY with 2 bytes queued -> next cycle DSR=x8000, KBSR=x0000; a later i_Tx_Done causes no o_Tx_DV pulse.
